uart_apb_ctrl: RTL and testbench
================================

Name: uart_apb_ctrl

Overview:
APB register front-end and TX scheduler for the UART core.
- Decodes APB transfers into the configuration registers, the TX FIFO push port and the RX FIFO pop port.
- Drains the TX FIFO into the transmitter with a tx_start/tx_done handshake.
- Sits between the APB bus and the FIFOs/baud generator inside uart_top.

Parameters:
D_W, 8, UART data/FIFO word width
APB_DW, 8, APB data width; equals D_W
ADDR_W, 8, PADDR width
DIV_W, 16, baud divisor width (two byte registers)
DIV_RST, 54, divisor at reset (100 MHz clock, 16 ticks/bit, 115200 baud)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
PADDR  in  ADDR_W  APB address
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  APB write
PWDATA  in  APB_DW  APB write data
PREADY  out  1  transfer complete
PRDATA  out  APB_DW  read data, valid when PREADY=1
tx_ff_wr_en  out  1  TX FIFO push
tx_ff_din  out  D_W  TX FIFO push data
tx_ff_full  in  1  TX FIFO full
tx_ff_rd_en  out  1  TX FIFO pop
tx_ff_dout  in  D_W  TX FIFO head; valid 1 cycle after rd_en
tx_ff_empty  in  1  TX FIFO empty
rx_ff_rd_en  out  1  RX FIFO pop
rx_ff_dout  in  D_W  RX FIFO head; valid 1 cycle after rd_en
rx_ff_empty  in  1  RX FIFO empty
tx_data  out  D_W  byte to transmitter
tx_start  out  1  one-cycle frame start pulse
tx_done  in  1  transmitter frame-complete pulse
baud_div  out  DIV_W  committed baud divisor
rx_en  out  1  receiver enable
tx_ff_clr  out  1  one-cycle TX FIFO flush
rx_ff_clr  out  1  one-cycle RX FIFO flush

Behaviour:
- Reset (rst=0 at a clk edge):
  - PREADY=0, PRDATA=0, all FIFO strobes and clears =0, tx_start=0, tx_data=0.
  - baud_div=DIV_RST, shadow low byte=DIV_RST[7:0], tx_en=1, rx_en=1, sticky flags=0.
  - Both FSMs return to IDLE. Any in-flight APB access or frame is abandoned.
- Register map (PADDR):
  - 0x00 RXDATA (RO, pops).
  - 0x01 TXDATA (WO, pushes).
  - 0x02 DIV_LO (RW, shadow).
  - 0x03 DIV_HI (RW, commit).
  - 0x04 CTRL: [0] tx_en, [1] rx_en, [2] tx_ff_clr, [3] rx_ff_clr. Bits [3:2] are self-clearing and read 0.
  - 0x05 STATUS (RO): [0] rx_empty, [1] tx_full, [2] tx_busy, [3] rx_underrun, [4] tx_overrun, [5] cfg_err.
  - Unmapped addresses: reads return 0x00, writes are ignored.
- APB FSM, states A_IDLE, A_ACCESS, A_WAIT:
  - A_IDLE -> A_ACCESS when PSEL=1 and PENABLE=1.
  - Default: PREADY is asserted exactly one cycle, registered, in the cycle after entering A_ACCESS. Side effects commit once, in that cycle.
  - After PREADY, the FSM returns to A_IDLE and ignores PSEL/PENABLE for that cycle, so a held PENABLE cannot double-commit.
- RXDATA read, non-empty FIFO:
  - A_ACCESS asserts rx_ff_rd_en for 1 cycle, then goes to A_WAIT.
  - A_WAIT captures rx_ff_dout into PRDATA with PREADY=1. Latency is 2 cycles.
- RXDATA read, empty FIFO: no pop, PRDATA=0x00, rx_underrun set.
- TXDATA write:
  - Not full: tx_ff_wr_en=1 and tx_ff_din=PWDATA for 1 cycle.
  - Full (sampled in the commit cycle): data dropped, tx_overrun set. PREADY is still returned.
- DIV_LO write updates the shadow only.
- DIV_HI write:
  - baud_div={PWDATA, shadow} commits atomically.
  - A result of 0 is rejected: baud_div unchanged, cfg_err set.
  - DIV_LO reads the shadow; DIV_HI reads baud_div[15:8].
- STATUS read returns the current value, then clears bits [5:3] in the same commit cycle. A flag set in that same cycle wins over the clear.
- TX scheduler FSM, states T_IDLE, T_LOAD, T_START, T_WAIT:
  - T_IDLE -> T_LOAD when tx_en=1 and tx_ff_empty=0; tx_ff_rd_en=1 for 1 cycle.
  - T_LOAD -> T_START: latch tx_ff_dout into tx_data.
  - T_START: tx_start=1 for 1 cycle -> T_WAIT.
  - T_WAIT -> T_IDLE on tx_done=1.
  - tx_busy = state != T_IDLE.
- Scheduler boundary cases:
  - tx_en cleared mid-frame: the current frame completes, and no new pop occurs.
  - tx_ff_clr during T_WAIT: the frame completes; the FIFO flush is the FIFO's responsibility.
  - tx_done seen outside T_WAIT is ignored.
  - An APB push and a scheduler pop in the same cycle are both issued.
- Back-to-back frames: T_WAIT -> T_IDLE -> T_LOAD with no extra idle cycles, so there are 3 cycles from tx_done to the next tx_start.

Decomposition:
- uart_pkg holds:
  - register address localparams (REG_RXDATA..REG_STATUS);
  - STATUS/CTRL bit index constants;
  - apb_state_t and tx_state_t enums.
- Sub-module uart_tx_sched contains the TX scheduler FSM, with tx_en and the FIFO pop/transmitter ports.

Test Plan:
1. Reset, then read 0x03/0x02 -> 0x00/0x36. Write 0x02=0x1B then 0x03=0x00 -> baud_div=0x001B, committed only after the 0x03 write.
2. Write 0x03=0x00 with shadow 0x00 -> baud_div unchanged; STATUS reads 0x20 then 0x00.
3. Preload RX FIFO with 0x55,0xDF; read 0x00 three times -> PRDATA 0x55, 0xDF (each PREADY 2 cycles after access), then 0x00; STATUS bit3=1.
4. Write 0x01 with 0xA5 and 0x3C; model tx_done 100 cycles after each tx_start -> tx_start pulses carry tx_data 0xA5 then 0x3C, 3 cycles apart after tx_done.
5. Fill TX FIFO with tx_en=0, write 0x01=0x77 -> no push, STATUS bit4=1, bit1=1, tx_start never pulses; set tx_en=1 -> draining begins.
6. Assert rst low during T_WAIT -> next cycle tx_start=0, PREADY=0, baud_div=54, and a late tx_done is ignored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared register map, bit positions and FSM state types for the UART
// APB front-end and its TX scheduler.
package uart_pkg;

  localparam logic [7:0] REG_RXDATA = 8'h00;
  localparam logic [7:0] REG_TXDATA = 8'h01;
  localparam logic [7:0] REG_DIV_LO = 8'h02;
  localparam logic [7:0] REG_DIV_HI = 8'h03;
  localparam logic [7:0] REG_CTRL   = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h05;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_RX_EN  = 1;
  localparam int CTRL_TX_CLR = 2;
  localparam int CTRL_RX_CLR = 3;

  localparam int ST_RX_EMPTY    = 0;
  localparam int ST_TX_FULL     = 1;
  localparam int ST_TX_BUSY     = 2;
  localparam int ST_RX_UNDERRUN = 3;
  localparam int ST_TX_OVERRUN  = 4;
  localparam int ST_CFG_ERR     = 5;

  typedef enum logic [1:0] {A_IDLE, A_ACCESS, A_WAIT} apb_state_t;
  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_START, T_WAIT} tx_state_t;

endpackage

// File: rtl/uart_tx_sched.sv
// TX scheduler: pops one byte from the TX FIFO, hands it to the transmitter
// with a one-cycle start pulse and waits for the frame-complete pulse.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int D_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tx_en,
  input  logic           tx_ff_empty,
  input  logic [D_W-1:0] tx_ff_dout,
  input  logic           tx_done,
  output logic           tx_ff_rd_en,
  output logic [D_W-1:0] tx_data,
  output logic           tx_start,
  output logic           tx_busy
);

  tx_state_t state, next_state;

  always_ff @(posedge clk) begin
    if (!rst) state <= T_IDLE;
    else      state <= next_state;
  end

  // tx_en only gates new pops; a frame already in T_WAIT always runs to tx_done.
  always_comb begin
    next_state = state;
    case (state)
      T_IDLE:  if (tx_en && !tx_ff_empty) next_state = T_LOAD;
      T_LOAD:  next_state = T_START;
      T_START: next_state = T_WAIT;
      T_WAIT:  if (tx_done) next_state = T_IDLE;
      default: next_state = T_IDLE;
    endcase
  end

  always_comb begin
    tx_ff_rd_en = rst && (state == T_IDLE) && tx_en && !tx_ff_empty;
    tx_start    = (state == T_START);
    tx_busy     = (state != T_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst)                  tx_data <= '0;
    else if (state == T_LOAD)  tx_data <= tx_ff_dout;
  end

endmodule

// File: rtl/uart_apb_ctrl.sv
// APB register front-end for the UART: config registers, TX FIFO push,
// RX FIFO pop with a one-cycle read-data wait, and the TX scheduler.
module uart_apb_ctrl
  import uart_pkg::*;
#(
  parameter int D_W     = 8,
  parameter int APB_DW  = 8,
  parameter int ADDR_W  = 8,
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 54
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [APB_DW-1:0] PWDATA,
  output logic              PREADY,
  output logic [APB_DW-1:0] PRDATA,
  output logic              tx_ff_wr_en,
  output logic [D_W-1:0]    tx_ff_din,
  input  logic              tx_ff_full,
  output logic              tx_ff_rd_en,
  input  logic [D_W-1:0]    tx_ff_dout,
  input  logic              tx_ff_empty,
  output logic              rx_ff_rd_en,
  input  logic [D_W-1:0]    rx_ff_dout,
  input  logic              rx_ff_empty,
  output logic [D_W-1:0]    tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic [DIV_W-1:0]  baud_div,
  output logic              rx_en,
  output logic              tx_ff_clr,
  output logic              rx_ff_clr
);

  localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);

  apb_state_t a_state, a_next;

  logic              tx_en;
  logic              tx_busy;
  logic [APB_DW-1:0] div_shadow;
  logic [DIV_W-1:0]  div_cand;
  logic              rx_underrun, tx_overrun, cfg_err;
  logic              set_underrun, set_overrun, set_cfg_err, status_clr;
  logic              commit;
  logic [APB_DW-1:0] status, ctrl_rd, rd_mux;

  always_ff @(posedge clk) begin
    if (!rst) a_state <= A_IDLE;
    else      a_state <= a_next;
  end

  // PREADY high in A_IDLE marks the completion cycle; ignoring PENABLE there
  // keeps a held access phase from committing twice.
  always_comb begin
    a_next = a_state;
    case (a_state)
      A_IDLE:   if (PSEL && PENABLE && !PREADY) a_next = A_ACCESS;
      A_ACCESS: a_next = rx_ff_rd_en ? A_WAIT : A_IDLE;
      A_WAIT:   a_next = A_IDLE;
      default:  a_next = A_IDLE;
    endcase
  end

  always_comb begin
    rx_ff_rd_en  = (a_state == A_ACCESS) && !PWRITE && (PADDR == REG_RXDATA) && !rx_ff_empty;
    commit       = (a_state == A_ACCESS) && !rx_ff_rd_en;
    div_cand     = {PWDATA, div_shadow};
    set_underrun = commit && !PWRITE && (PADDR == REG_RXDATA);
    set_overrun  = commit && PWRITE && (PADDR == REG_TXDATA) && tx_ff_full;
    set_cfg_err  = commit && PWRITE && (PADDR == REG_DIV_HI) && (div_cand == '0);
    status_clr   = commit && !PWRITE && (PADDR == REG_STATUS);
  end

  always_comb begin
    status                 = '0;
    status[ST_RX_EMPTY]    = rx_ff_empty;
    status[ST_TX_FULL]     = tx_ff_full;
    status[ST_TX_BUSY]     = tx_busy;
    status[ST_RX_UNDERRUN] = rx_underrun;
    status[ST_TX_OVERRUN]  = tx_overrun;
    status[ST_CFG_ERR]     = cfg_err;
    ctrl_rd                = '0;
    ctrl_rd[CTRL_TX_EN]    = tx_en;
    ctrl_rd[CTRL_RX_EN]    = rx_en;
    case (PADDR)
      REG_DIV_LO: rd_mux = div_shadow;
      REG_DIV_HI: rd_mux = baud_div[DIV_W-1:APB_DW];
      REG_CTRL:   rd_mux = ctrl_rd;
      REG_STATUS: rd_mux = status;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      PREADY      <= 1'b0;
      PRDATA      <= '0;
      tx_ff_wr_en <= 1'b0;
      tx_ff_din   <= '0;
      tx_ff_clr   <= 1'b0;
      rx_ff_clr   <= 1'b0;
      baud_div    <= DIV_RST_V;
      div_shadow  <= DIV_RST_V[APB_DW-1:0];
      tx_en       <= 1'b1;
      rx_en       <= 1'b1;
    end else begin
      PREADY      <= 1'b0;
      tx_ff_wr_en <= 1'b0;
      tx_ff_clr   <= 1'b0;
      rx_ff_clr   <= 1'b0;
      if (a_state == A_WAIT) begin
        PREADY <= 1'b1;
        PRDATA <= rx_ff_dout;
      end else if (commit) begin
        PREADY <= 1'b1;
        PRDATA <= PWRITE ? '0 : rd_mux;
        if (PWRITE) begin
          case (PADDR)
            REG_TXDATA: if (!tx_ff_full) begin
              tx_ff_wr_en <= 1'b1;
              tx_ff_din   <= PWDATA;
            end
            REG_DIV_LO: div_shadow <= PWDATA;
            REG_DIV_HI: if (div_cand != '0) baud_div <= div_cand;
            REG_CTRL: begin
              tx_en     <= PWDATA[CTRL_TX_EN];
              rx_en     <= PWDATA[CTRL_RX_EN];
              tx_ff_clr <= PWDATA[CTRL_TX_CLR];
              rx_ff_clr <= PWDATA[CTRL_RX_CLR];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Set terms are ORed after the clear so a same-cycle event is never lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_underrun <= 1'b0;
      tx_overrun  <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      rx_underrun <= (rx_underrun & ~status_clr) | set_underrun;
      tx_overrun  <= (tx_overrun  & ~status_clr) | set_overrun;
      cfg_err     <= (cfg_err     & ~status_clr) | set_cfg_err;
    end
  end

  uart_tx_sched #(.D_W(D_W)) u_tx_sched (
    .clk         (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .tx_ff_empty (tx_ff_empty),
    .tx_ff_dout  (tx_ff_dout),
    .tx_done     (tx_done),
    .tx_ff_rd_en (tx_ff_rd_en),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy)
  );

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Bench for uart_apb_ctrl: APB master tasks, behavioural FIFOs and
// transmitter, and a scoreboard for read data and transmitted bytes.
module tb_uart_apb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  PADDR = 8'h00;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]  PWDATA = 8'h00;
  logic        PREADY;
  logic [7:0]  PRDATA;
  logic        tx_ff_wr_en, tx_ff_rd_en, rx_ff_rd_en;
  logic [7:0]  tx_ff_din;
  logic        tx_ff_full, tx_ff_empty, rx_ff_empty;
  logic [7:0]  tx_ff_dout = 8'h00, rx_ff_dout = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic [15:0] baud_div;
  logic        rx_en, tx_ff_clr, rx_ff_clr;

  int n_vec = 0, n_err = 0;
  int cyc = 0, start_cnt = 0, last_start_cyc = 0, last_done_cyc = 0;
  int tx_clr_cnt = 0, rx_clr_cnt = 0;
  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  uart_apb_ctrl dut (
    .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA),
    .tx_ff_wr_en(tx_ff_wr_en), .tx_ff_din(tx_ff_din), .tx_ff_full(tx_ff_full),
    .tx_ff_rd_en(tx_ff_rd_en), .tx_ff_dout(tx_ff_dout), .tx_ff_empty(tx_ff_empty),
    .rx_ff_rd_en(rx_ff_rd_en), .rx_ff_dout(rx_ff_dout), .rx_ff_empty(rx_ff_empty),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .baud_div(baud_div),
    .rx_en(rx_en), .tx_ff_clr(tx_ff_clr), .rx_ff_clr(rx_ff_clr)
  );

  // RX FIFO model: preloaded by the stimulus, head registered one cycle after a pop.
  logic [7:0] rx_mem [16];
  int rx_rd = 0, rx_wr = 0;
  assign rx_ff_empty = (rx_rd == rx_wr);
  always @(posedge clk) begin
    if (rx_ff_rd_en && (rx_rd != rx_wr)) begin
      rx_ff_dout <= rx_mem[rx_rd];
      rx_rd      <= rx_rd + 1;
    end
  end

  // TX FIFO model, depth 4.
  logic [7:0] tx_mem [4];
  int tx_head = 0, tx_cnt = 0;
  assign tx_ff_full  = (tx_cnt == 4);
  assign tx_ff_empty = (tx_cnt == 0);
  always @(posedge clk) begin : tx_fifo_model
    int c;
    if (tx_ff_clr) begin
      tx_cnt <= 0;
    end else begin
      c = tx_cnt;
      if (tx_ff_rd_en && tx_cnt > 0) begin
        tx_ff_dout <= tx_mem[tx_head];
        tx_head    <= (tx_head + 1) % 4;
        c = c - 1;
      end
      if (tx_ff_wr_en && tx_cnt < 4) begin
        tx_mem[(tx_head + tx_cnt) % 4] <= tx_ff_din;
        c = c + 1;
      end
      tx_cnt <= c;
    end
  end

  // Transmitter model: tx_done pulses 100 cycles after each tx_start, ignoring rst.
  int txm_cnt = 0;
  always @(posedge clk) begin
    tx_done <= (txm_cnt == 1);
    if (tx_start)         txm_cnt <= 99;
    else if (txm_cnt > 0) txm_cnt <= txm_cnt - 1;
    if (tx_ff_clr) tx_clr_cnt <= tx_clr_cnt + 1;
    if (rx_ff_clr) rx_clr_cnt <= rx_clr_cnt + 1;
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes a read or starts a frame.
  always @(negedge clk) begin
    if (rst && PREADY && !PWRITE) begin
      if (rd_q.size() == 0) checkOutput("rd_resp_expected", rd_q.size(), 1);
      else begin
        mon_exp = rd_q.pop_front();
        checkOutput("prdata", PRDATA, mon_exp);
      end
    end
    if (rst && tx_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      if (tx_q.size() == 0) checkOutput("tx_start_expected", tx_q.size(), 1);
      else begin
        mon_exp = tx_q.pop_front();
        checkOutput("tx_data", tx_data, mon_exp);
      end
    end
    if (tx_done) last_done_cyc = cyc;
  end

  // One APB transfer; for reads, data is the expected PRDATA queued for the monitor.
  task automatic applyStimulus(input logic [7:0] addr, input logic wr,
                               input logic [7:0] data, input int exp_lat);
    int lat;
    if (!wr) rd_q.push_back(data);
    @(posedge clk); #1;
    PADDR = addr; PWRITE = wr; PWDATA = wr ? data : 8'h00; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!PREADY && lat < 20);
    PSEL = 1'b0; PENABLE = 1'b0;
    checkOutput($sformatf("latency_%s_%02h", wr ? "wr" : "rd", addr), lat, exp_lat);
  endtask

  task automatic waitStarts(input int target, input int budget);
    int b = budget;
    while (start_cnt < target && b > 0) begin
      @(posedge clk);
      b--;
    end
    checkOutput("tx_start_count", start_cnt, target);
  endtask

  initial begin
    int s;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pready", PREADY, 0);
    checkOutput("rst_prdata", PRDATA, 0);
    checkOutput("rst_baud_div", baud_div, 16'd54);
    checkOutput("rst_tx_start", tx_start, 0);
    checkOutput("rst_tx_wr_en", tx_ff_wr_en, 0);
    checkOutput("rst_rx_rd_en", rx_ff_rd_en, 0);
    checkOutput("rst_tx_clr", tx_ff_clr, 0);
    checkOutput("rst_rx_en", rx_en, 1);
    rst = 1'b1;

    // Divisor reset value, shadow/commit and unmapped address
    applyStimulus(8'h03, 0, 8'h00, 2);
    applyStimulus(8'h02, 0, 8'h36, 2);
    @(posedge clk); #1;
    checkOutput("pready_one_cycle", PREADY, 0);
    applyStimulus(8'h05, 0, 8'h01, 2);
    applyStimulus(8'h07, 1, 8'hFF, 2);
    applyStimulus(8'h07, 0, 8'h00, 2);
    applyStimulus(8'h02, 1, 8'h1B, 2);
    checkOutput("div_shadow_only", baud_div, 16'h0036);
    applyStimulus(8'h03, 1, 8'h00, 2);
    checkOutput("div_commit", baud_div, 16'h001B);
    applyStimulus(8'h02, 0, 8'h1B, 2);
    applyStimulus(8'h04, 1, 8'h0F, 2);
    applyStimulus(8'h04, 0, 8'h03, 2);
    checkOutput("tx_clr_pulses", tx_clr_cnt, 1);
    checkOutput("rx_clr_pulses", rx_clr_cnt, 1);

    // Zero divisor rejected, cfg_err read-to-clear
    rx_mem[0] = 8'h55; rx_mem[1] = 8'hDF; rx_wr = 2;
    applyStimulus(8'h02, 1, 8'h00, 2);
    applyStimulus(8'h03, 1, 8'h00, 2);
    checkOutput("div_reject", baud_div, 16'h001B);
    applyStimulus(8'h05, 0, 8'h20, 2);
    applyStimulus(8'h05, 0, 8'h00, 2);

    // RX pops with two-cycle latency, then underrun
    applyStimulus(8'h00, 0, 8'h55, 3);
    applyStimulus(8'h00, 0, 8'hDF, 3);
    applyStimulus(8'h00, 0, 8'h00, 2);
    checkOutput("rx_pop_count", rx_rd, 2);
    applyStimulus(8'h05, 0, 8'h09, 2);

    // Two back-to-back frames
    s = start_cnt;
    tx_q.push_back(8'hA5); tx_q.push_back(8'h3C);
    applyStimulus(8'h01, 1, 8'hA5, 2);
    applyStimulus(8'h01, 1, 8'h3C, 2);
    waitStarts(s + 2, 400);
    checkOutput("b2b_done_to_start", last_start_cyc - last_done_cyc, 3);
    repeat (110) @(posedge clk);

    // TX disabled: fill FIFO, overrun on full, then enable and drain
    applyStimulus(8'h04, 1, 8'h02, 2);
    applyStimulus(8'h01, 1, 8'h11, 2);
    applyStimulus(8'h01, 1, 8'h22, 2);
    applyStimulus(8'h01, 1, 8'h33, 2);
    applyStimulus(8'h01, 1, 8'h44, 2);
    applyStimulus(8'h01, 1, 8'h77, 2);
    s = start_cnt;
    applyStimulus(8'h05, 0, 8'h13, 2);
    applyStimulus(8'h05, 0, 8'h03, 2);
    repeat (50) @(posedge clk);
    checkOutput("no_start_when_disabled", start_cnt, s);
    tx_q.push_back(8'h11); tx_q.push_back(8'h22);
    tx_q.push_back(8'h33); tx_q.push_back(8'h44);
    applyStimulus(8'h04, 1, 8'h03, 2);
    waitStarts(s + 4, 600);
    repeat (110) @(posedge clk);
    applyStimulus(8'h05, 0, 8'h01, 2);

    // Reset in the middle of a frame
    s = start_cnt;
    tx_q.push_back(8'h9E);
    applyStimulus(8'h01, 1, 8'h9E, 2);
    waitStarts(s + 1, 50);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_tx_start", tx_start, 0);
    checkOutput("midrst_pready", PREADY, 0);
    checkOutput("midrst_prdata", PRDATA, 0);
    checkOutput("midrst_baud_div", baud_div, 16'd54);
    checkOutput("midrst_tx_rd_en", tx_ff_rd_en, 0);
    rst = 1'b1;
    applyStimulus(8'h05, 0, 8'h01, 2);
    repeat (100) @(posedge clk);
    applyStimulus(8'h05, 0, 8'h01, 2);
    applyStimulus(8'h04, 0, 8'h03, 2);
    checkOutput("late_done_no_start", start_cnt, s + 1);

    @(posedge clk); #1;
    checkOutput("rd_q_drained", rd_q.size(), 0);
    checkOutput("tx_q_drained", tx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
